// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator: a binary count is stepped per handshake and
// presented as a registered Gray word, with optional single-wrap runs.
//   state   | meaning
//   IDLE    | waiting for start; load presets the count
//   RUN     | presenting gray_out, stepping on each accepted transfer
//   DONE    | one-shot run finished its wrap; returns to IDLE
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bcnt_q, bcnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             os_q, os_d;
  logic             xfer;
  logic             at_edge;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    os_d    = os_q;
    wrap_d  = 1'b0;
    xfer    = (state_q == ST_RUN) && out_ready;
    at_edge = up_dn ? (bcnt_q == '1) : (bcnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bcnt_d = gray2bin(load_gray);
        end
        if (start) begin
          state_d = ST_RUN;
          os_d    = one_shot;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          bcnt_d = up_dn ? bcnt_q + 1'b1 : bcnt_q - 1'b1;
          wrap_d = at_edge;
        end
        // stop wins over a one-shot wrap; the transfer still lands either way
        if (stop) begin
          state_d = ST_IDLE;
          os_d    = 1'b0;
        end else if (xfer && at_edge && os_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        os_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        os_d    = 1'b0;
      end
    endcase

    gray_d = bcnt_d ^ (bcnt_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
      os_q    <= os_d;
    end
  end

  assign gray_out  = gray_q;
  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: directed scenarios with literal checks plus a
// cycle-by-cycle comparison against a phase/count model.
module tb_gray_seq_gen;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst, start, stop, up_dn, one_shot, load, out_ready;
  logic [W-1:0] load_gray;
  logic [W-1:0] gray_out;
  logic         out_valid, wrap, busy;

  int tests = 0;
  int fails = 0;

  gray_seq_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
    .one_shot(one_shot), .load(load), .load_gray(load_gray),
    .gray_out(gray_out), .out_valid(out_valid), .out_ready(out_ready),
    .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: phase 0=idle, 1=running, 2=finished; count is the plain integer position
  int m_phase = 0;
  int m_count = 0;
  bit m_os = 0;
  bit m_wrap = 0;
  bit m_adv = 0;
  bit m_live = 0;

  function automatic int gray_of(int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int index_of_gray(int g);
    for (int n = 0; n < MOD; n++) begin
      if (gray_of(n) == g) return n;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    m_live = 1;
    m_adv  = 0;
    m_wrap = 0;
    if (rst) begin
      m_phase = 0; m_count = 0; m_os = 0;
    end else begin
      case (m_phase)
        0: begin
          if (load) m_count = index_of_gray(int'(load_gray));
          if (start) begin m_phase = 1; m_os = one_shot; end
        end
        1: begin
          bit wrapped;
          wrapped = 0;
          if (out_ready) begin
            m_adv = 1;
            if (up_dn) begin
              wrapped = (m_count == MOD - 1);
              m_count = (m_count + 1) % MOD;
            end else begin
              wrapped = (m_count == 0);
              m_count = (m_count + MOD - 1) % MOD;
            end
            m_wrap = wrapped;
          end
          if (stop) begin m_phase = 0; m_os = 0; end
          else if (wrapped && m_os) m_phase = 2;
        end
        default: begin m_phase = 0; m_os = 0; end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] prev_gray = '0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_gray", int'(gray_out), gray_of(m_count));
      chk("model_valid", int'(out_valid), int'(m_phase == 1));
      chk("model_busy", int'(busy), int'(m_phase != 0));
      chk("model_wrap", int'(wrap), int'(m_wrap));
      if (m_adv && !rst) chk("one_bit_step", $countones(gray_out ^ prev_gray), 1);
    end
    prev_gray = gray_out;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lit[5];
    lit = '{0, 1, 3, 2, 6};
    rst = 1; start = 0; stop = 0; up_dn = 1; one_shot = 0; load = 0;
    out_ready = 0; load_gray = '0;
    step(2);
    rst = 0;
    chk("reset_gray", int'(gray_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);

    // count up through a full wrap
    start = 1; up_dn = 1; out_ready = 1;
    step(1); start = 0;
    chk("up_first", int'(gray_out), lit[0]);
    for (int i = 1; i < 5; i++) begin
      step(1);
      chk("up_seq", int'(gray_out), lit[i]);
    end
    step(11);
    chk("pre_wrap_gray", int'(gray_out), 4'b1000);
    chk("pre_wrap_wrap", int'(wrap), 0);
    step(1);
    chk("wrap_gray", int'(gray_out), 0);
    chk("wrap_pulse", int'(wrap), 1);
    step(1);
    chk("wrap_single", int'(wrap), 0);

    // stall at 0011
    step(1);
    chk("stall_at", int'(gray_out), 4'b0011);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_gray", int'(gray_out), 4'b0011);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_wrap", int'(wrap), 0);
    end
    load = 1; load_gray = 4'b1111; start = 1;
    step(1); load = 0; start = 0;
    chk("load_ignored_run", int'(gray_out), 4'b0011);
    stop = 1;
    step(1); stop = 0;
    chk("stop_idle_valid", int'(out_valid), 0);
    chk("stop_idle_busy", int'(busy), 0);

    // load 1100 then count down
    load = 1; load_gray = 4'b1100;
    step(1); load = 0;
    chk("load_gray", int'(gray_out), 4'b1100);
    chk("load_idle", int'(busy), 0);
    start = 1; up_dn = 0; out_ready = 1;
    step(1); start = 0;
    chk("dn_0", int'(gray_out), 4'b1100);
    step(1);
    chk("dn_1", int'(gray_out), 4'b0100);
    step(1);
    chk("dn_2", int'(gray_out), 4'b0101);
    stop = 1;
    step(1); stop = 0;
    chk("dn_stop_gray", int'(gray_out), 4'b0111);
    chk("dn_stop_valid", int'(out_valid), 0);

    // one-shot from 1000 with load and start together
    load = 1; load_gray = 4'b1000; start = 1; one_shot = 1; up_dn = 1;
    step(1); load = 0; start = 0; one_shot = 0;
    chk("os_first", int'(gray_out), 4'b1000);
    chk("os_valid", int'(out_valid), 1);
    step(1);
    chk("os_wrap_gray", int'(gray_out), 0);
    chk("os_wrap", int'(wrap), 1);
    chk("os_done_valid", int'(out_valid), 0);
    chk("os_done_busy", int'(busy), 1);
    step(1);
    chk("os_idle_busy", int'(busy), 0);
    chk("os_idle_wrap", int'(wrap), 0);

    // stop coincident with a transfer at 0001
    start = 1;
    step(1); start = 0;
    chk("st_0", int'(gray_out), 0);
    step(1);
    chk("st_1", int'(gray_out), 4'b0001);
    stop = 1;
    step(1); stop = 0;
    chk("st_gray", int'(gray_out), 4'b0011);
    chk("st_valid", int'(out_valid), 0);

    // reset mid-run, right at a wrap-causing transfer
    load = 1; load_gray = 4'b1000; start = 1;
    step(1); load = 0; start = 0;
    rst = 1;
    step(1); rst = 0;
    chk("rst_gray", int'(gray_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_busy", int'(busy), 0);

    // pseudo-random soak, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      up_dn     = $urandom_range(0, 1);
      one_shot  = $urandom_range(0, 1);
      load      = ($urandom_range(0, 5) == 0);
      load_gray = W'($urandom_range(0, MOD - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 0; start = 0; stop = 0; load = 0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the code width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, begins a sequence from IDLE.
REQ-005 SHALL have port stop, input, 1, ends a running sequence.
REQ-006 SHALL have port up_dn, input, 1, direction: 1 = count up, 0 = count down.
REQ-007 SHALL have port one_shot, input, 1, when 1 at start, ends the sequence after one full wrap.
REQ-008 SHALL have port load, input, 1, preset strobe, honoured in IDLE only.
REQ-009 SHALL have port load_gray, input, WIDTH, Gray-coded preset value.
REQ-010 SHALL have port gray_out, output, WIDTH, current Gray code word for the downstream Gray-to-binary stage.
REQ-011 SHALL have port out_valid, output, 1, gray_out is presented for transfer.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts gray_out.
REQ-013 SHALL have port wrap, output, 1, one-cycle pulse on modulo wrap.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL hold an internal WIDTH-bit binary count bcnt; gray_out SHALL be a register equal to bcnt ^ (bcnt >> 1), with no combinational path from any input.
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE: out_valid=0; start=1 -> RUN next cycle; stop ignored.
REQ-018 load=1 in IDLE SHALL set bcnt to the binary value of load_gray, with gray_out equal to load_gray next cycle; load is ignored in RUN and DONE.
REQ-019 load and start in the same IDLE cycle SHALL apply the load, so the first word presented in RUN is the loaded value.
REQ-020 one_shot SHALL be sampled only on the start cycle and held for the whole sequence.
REQ-021 RUN: out_valid=1; a transfer occurs in a cycle with out_valid && out_ready.
REQ-022 On a transfer, bcnt SHALL advance by +1 (up_dn=1) or -1 (up_dn=0) modulo 2^WIDTH, and gray_out SHALL update the next cycle; up_dn is sampled per transfer.
REQ-023 Without a transfer (out_ready=0), gray_out and bcnt SHALL hold; out_valid SHALL stay 1.
REQ-024 wrap SHALL pulse high for exactly one cycle, the cycle after a transfer in which bcnt went from all-ones to 0 (up) or from 0 to all-ones (down).
REQ-025 In RUN with one_shot latched, a wrapping transfer SHALL move the FSM to DONE, not RUN.
REQ-026 DONE: out_valid=0, busy=1; SHALL go to IDLE unconditionally the next cycle; bcnt retains the wrapped value.
REQ-027 stop=1 in RUN SHALL move the FSM to IDLE next cycle; a transfer in the same cycle still completes (bcnt advances, wrap rules apply).
REQ-028 start in RUN or DONE SHALL be ignored.
REQ-029 Consecutive gray_out values on successive transfers SHALL differ in exactly one bit, including across the wrap.

Reset
REQ-030 rst=1 at a clock edge SHALL force state=IDLE, bcnt=0, gray_out=0, out_valid=0, wrap=0, busy=0 and the latched one_shot=0, overriding all other inputs.
REQ-031 rst asserted mid-RUN or in DONE SHALL abort the sequence with no wrap pulse after the reset edge.

Verification
REQ-032 Reset, start, up_dn=1, out_ready=1, WIDTH=4 -> gray_out 0000, 0001, 0011, 0010, 0110...; after 16 transfers gray_out=0000 and wrap pulses once.
REQ-033 While RUN shows 0011, hold out_ready=0 for 3 cycles -> gray_out stays 0011, out_valid stays 1, no wrap.
REQ-034 In IDLE, load with load_gray=1100, then start, up_dn=0 -> gray_out 1100, 0100, 0101 on successive transfers.
REQ-035 Load 1000 (bin 15), start with one_shot=1, up_dn=1 -> first transfer gives gray_out=0000 with a wrap pulse; then DONE for one cycle (out_valid=0, busy=1), then IDLE (busy=0).
REQ-036 stop together with a transfer at 0001 -> gray_out=0011, then IDLE with out_valid=0; rst during RUN -> all outputs 0 on the next cycle.
